// File: rtl/corefifo_fwft_pkg.sv
// Shared constants and helpers for the corefifo FWFT output stage.
package corefifo_fwft_pkg;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 3;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

  // Two extra entries beyond the RAM latency let the stage keep one word per
  // cycle flowing while credits for the in-flight reads are outstanding.
  function automatic int fwft_depth(input int rd_lat);
    return rd_lat + 2;
  endfunction

endpackage

// File: rtl/corefifo_fwft_pipe_if.sv
// Controller-side and consumer-side signals of the FWFT output stage.
interface corefifo_fwft_pipe_if #(
  parameter int DWIDTH = 18,
  parameter int LW     = 2
);
  logic              flush;
  logic              fifo_empty;
  logic              fifo_aempty;
  logic              fifo_rd_en;
  logic [DWIDTH-1:0] fifo_dout;
  logic              rd_en;
  logic [DWIDTH-1:0] dout;
  logic              dout_valid;
  logic              empty;
  logic              aempty;
  logic [LW-1:0]     level;
  logic              underflow;

  // The FWFT stage itself.
  modport master (
    input  flush, fifo_empty, fifo_aempty, fifo_dout, rd_en,
    output fifo_rd_en, dout, dout_valid, empty, aempty, level, underflow
  );

  // The surrounding controller/RAM and consumer.
  modport slave (
    output flush, fifo_empty, fifo_aempty, fifo_dout, rd_en,
    input  fifo_rd_en, dout, dout_valid, empty, aempty, level, underflow
  );
endinterface

// File: rtl/corefifo_fwft_skidbuf.sv
// Small circular register buffer holding prefetched words for the FWFT stage.
module corefifo_fwft_skidbuf
  import corefifo_fwft_pkg::*;
#(
  parameter int DWIDTH = 18,
  parameter int DEPTH  = 3,
  parameter int LW     = clog2(DEPTH + 1)
) (
  input  logic              pos_rclk,
  input  logic              aresetn,
  input  logic              clear,
  input  logic              push,
  input  logic [DWIDTH-1:0] push_data,
  input  logic              pop,
  output logic [DWIDTH-1:0] dout,
  output logic [LW-1:0]     level
);
  localparam int PW = (DEPTH > 1) ? clog2(DEPTH) : 1;
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

  logic [DWIDTH-1:0] buf_mem [DEPTH];
  logic [PW-1:0]     wr_ptr_reg;
  logic [PW-1:0]     rd_ptr_reg;
  logic [LW-1:0]     level_reg;
  logic [DWIDTH-1:0] hold_reg;

  // DEPTH is generally not a power of two, so wrap explicitly.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
    return (ptr == PTR_LAST) ? '0 : ptr + PW'(1);
  endfunction

  // Data array: written on arrival, never reset (pointers/level qualify it).
  always_ff @(posedge pos_rclk) begin
    if (push && !clear) begin
      buf_mem[wr_ptr_reg] <= push_data;
    end
  end

  // Pointer/level bookkeeping; clear wins over any push or pop.
  always_ff @(posedge pos_rclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
      hold_reg   <= '0;
    end else begin
      hold_reg <= dout;
      if (clear) begin
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
        level_reg  <= '0;
      end else begin
        if (push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
        if (pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
        level_reg <= level_reg + LW'(push) - LW'(pop);
      end
    end
  end

  // Head word while occupied; otherwise keep showing whatever was last shown.
  assign dout  = (level_reg != '0) ? buf_mem[rd_ptr_reg] : hold_reg;
  assign level = level_reg;

endmodule

// File: rtl/corefifo_fwft_pipe.sv
// FWFT output stage for corefifo with credit-based prefetch over a RAM read
// latency of RD_LAT cycles; rd_en never reaches fifo_rd_en combinationally.
module corefifo_fwft_pipe
  import corefifo_fwft_pkg::*;
#(
  parameter int DWIDTH        = 18,
  parameter int RD_LAT        = 1,
  parameter int AEMPTY_THRESH = 1,
  parameter bit READ_LOW      = 1'b0
) (
  input logic                  pos_rclk,
  input logic                  aresetn,
  corefifo_fwft_pipe_if.master bus
);
  localparam int DEPTH = fwft_depth(RD_LAT);
  localparam int LW    = clog2(DEPTH + 1);

  if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_rd_lat_check
    $error("corefifo_fwft_pipe: RD_LAT=%0d outside %0d..%0d", RD_LAT, RD_LAT_MIN, RD_LAT_MAX);
  end

  logic [RD_LAT-1:0] pipe_reg;
  logic              underflow_reg;
  logic [LW-1:0]     level_w;
  logic [DWIDTH-1:0] dout_w;
  logic [LW:0]       credit_used;
  logic              re_p;
  logic              dout_valid;
  logic              pop;
  logic              arrival;
  logic              issue;

  assign re_p       = READ_LOW ? ~bus.rd_en : bus.rd_en;
  assign dout_valid = (level_w != '0);
  assign pop        = re_p & dout_valid & ~bus.flush;
  assign arrival    = pipe_reg[RD_LAT-1];

  // Credits in use: words held plus reads still travelling through the RAM.
  always_comb begin
    credit_used = {1'b0, level_w};
    for (int i = 0; i < RD_LAT; i++) begin
      credit_used = credit_used + (LW + 1)'(pipe_reg[i]);
    end
  end

  // Only registered occupancy is used, so a same-cycle pop earns no credit.
  assign issue = aresetn & ~bus.fifo_empty & ~bus.flush &
                 (credit_used < (LW + 1)'(DEPTH));

  // In-flight tracker: one bit per outstanding read, tail bit marks arrival.
  always_ff @(posedge pos_rclk or negedge aresetn) begin
    if (!aresetn) begin
      pipe_reg <= '0;
    end else if (bus.flush) begin
      pipe_reg <= '0;
    end else begin
      pipe_reg <= RD_LAT'({pipe_reg, issue});
    end
  end

  // Underflow flags a consumer pop attempted while nothing is held.
  always_ff @(posedge pos_rclk or negedge aresetn) begin
    if (!aresetn) begin
      underflow_reg <= 1'b0;
    end else begin
      underflow_reg <= re_p & ~dout_valid;
    end
  end

  corefifo_fwft_skidbuf #(
    .DWIDTH (DWIDTH),
    .DEPTH  (DEPTH),
    .LW     (LW)
  ) u_skidbuf (
    .pos_rclk  (pos_rclk),
    .aresetn   (aresetn),
    .clear     (bus.flush),
    .push      (arrival),
    .push_data (bus.fifo_dout),
    .pop       (pop),
    .dout      (dout_w),
    .level     (level_w)
  );

  assign bus.fifo_rd_en = issue;
  assign bus.dout       = dout_w;
  assign bus.dout_valid = dout_valid;
  assign bus.empty      = ~dout_valid;
  assign bus.aempty     = ~dout_valid | (bus.fifo_aempty & (int'(level_w) <= AEMPTY_THRESH));
  assign bus.level      = level_w;
  assign bus.underflow  = underflow_reg;

endmodule
